// File: rtl/sif_xa_master.sv
// sif_xa_master: SIF external-access bus initiator; one read/write command in flight at a time.
// Latency: write strobe 1 cycle after accept; read response RD_LAT+2 cycles after accept.
// Backpressure: cmd_ready low while busy; rsp_valid/rsp_rdata held indefinitely until rsp_ready.
//
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op 1=write 0=read, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready        read response handshake; rsp_rdata holds captured data
//   busy                       high whenever a command is being processed
//   xa_addr, xa_data_wr        registered bus address / write data, held between transactions
//   xa_wr_s, xa_rd_s           registered one-cycle write / read strobes
//   xa_data_rd                 responder read data, sampled only at the capture edge
module sif_xa_master #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int RD_LAT = 1     // responder read latency, legal 1..7
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,

   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,

   output logic          busy,

   output logic [AW-1:0] xa_addr,
   output logic [DW-1:0] xa_data_wr,
   output logic          xa_wr_s,
   output logic          xa_rd_s,
   input  logic [DW-1:0] xa_data_rd
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_RESP = 3'd4
   } state_t;

   // WAIT lasts RD_LAT cycles: the counter starts at RD_LAT-1 and the
   // capture happens in the cycle where it reads zero.
   localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] lat_cnt;
   logic       cmd_hs;
   logic       lat_done;

   assign cmd_hs   = cmd_valid && (state == S_IDLE);
   assign lat_done = (state == S_WAIT) && (lat_cnt == 3'd0);

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_hs) begin
               state_nxt = cmd_op ? S_WR : S_RD;
            end
         end
         S_WR:   state_nxt = S_IDLE;
         S_RD:   state_nxt = S_WAIT;
         S_WAIT: begin
            if (lat_done) begin
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Read latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt <= 3'd0;
      end else if (state == S_RD) begin
         lat_cnt <= LAT_LOAD;
      end else if ((state == S_WAIT) && (lat_cnt != 3'd0)) begin
         lat_cnt <= lat_cnt - 3'd1;
      end
   end

   // Bus address/data: loaded on accept, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xa_addr    <= '0;
         xa_data_wr <= '0;
      end else if (cmd_hs) begin
         xa_addr <= cmd_addr;
         if (cmd_op) begin
            xa_data_wr <= cmd_wdata;
         end
      end
   end

   // Strobes are registered from the next state so they line up exactly
   // with the WR/RD state cycle and drop on reset without glitching.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xa_wr_s <= 1'b0;
         xa_rd_s <= 1'b0;
      end else begin
         xa_wr_s <= (state_nxt == S_WR);
         xa_rd_s <= (state_nxt == S_RD);
      end
   end

   // Read data capture at the end of the last WAIT cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
      end else if (lat_done) begin
         rsp_rdata <= xa_data_rd;
      end
   end

   // cmd_ready is gated by rst_n so every output reads 0 while reset is held.
   assign cmd_ready = (state == S_IDLE) && rst_n;
   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sif_xa_master.sv
module tb_sif_xa_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_op;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_ready;
   logic [15:0] xa_data_rd;
   logic        use_lat1;

   logic        d1_cmd_ready, d1_rsp_valid, d1_busy, d1_xa_wr_s, d1_xa_rd_s;
   logic [15:0] d1_rsp_rdata, d1_xa_addr, d1_xa_data_wr;
   logic        d3_cmd_ready, d3_rsp_valid, d3_busy, d3_xa_wr_s, d3_xa_rd_s;
   logic [15:0] d3_rsp_rdata, d3_xa_addr, d3_xa_data_wr;

   logic        o_cmd_ready, o_rsp_valid, o_busy, o_xa_wr_s, o_xa_rd_s;
   logic [15:0] o_rsp_rdata, o_xa_addr, o_xa_data_wr;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] resp_mem [logic [15:0]];  // responder contents
   logic [15:0] exp_mem  [logic [15:0]];  // bench reference of what reads must return
   logic [15:0] exp_rsp [$];              // expected read responses, in order
   logic [32:0] exp_bus [$];              // expected bus ops {op, addr, wdata}

   sif_xa_master #(.AW(16), .DW(16), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & use_lat1), .cmd_ready(d1_cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready | ~use_lat1), .rsp_rdata(d1_rsp_rdata),
      .busy(d1_busy),
      .xa_addr(d1_xa_addr), .xa_data_wr(d1_xa_data_wr),
      .xa_wr_s(d1_xa_wr_s), .xa_rd_s(d1_xa_rd_s), .xa_data_rd(xa_data_rd)
   );

   sif_xa_master #(.AW(16), .DW(16), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid & ~use_lat1), .cmd_ready(d3_cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready | use_lat1), .rsp_rdata(d3_rsp_rdata),
      .busy(d3_busy),
      .xa_addr(d3_xa_addr), .xa_data_wr(d3_xa_data_wr),
      .xa_wr_s(d3_xa_wr_s), .xa_rd_s(d3_xa_rd_s), .xa_data_rd(xa_data_rd)
   );

   assign o_cmd_ready  = use_lat1 ? d1_cmd_ready  : d3_cmd_ready;
   assign o_rsp_valid  = use_lat1 ? d1_rsp_valid  : d3_rsp_valid;
   assign o_busy       = use_lat1 ? d1_busy       : d3_busy;
   assign o_xa_wr_s    = use_lat1 ? d1_xa_wr_s    : d3_xa_wr_s;
   assign o_xa_rd_s    = use_lat1 ? d1_xa_rd_s    : d3_xa_rd_s;
   assign o_rsp_rdata  = use_lat1 ? d1_rsp_rdata  : d3_rsp_rdata;
   assign o_xa_addr    = use_lat1 ? d1_xa_addr    : d3_xa_addr;
   assign o_xa_data_wr = use_lat1 ? d1_xa_data_wr : d3_xa_data_wr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] exp_rd(input logic [15:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : 16'h0000;
   endfunction

   // Responder: stores writes; drives read data only in cycle strobe+lat,
   // 0xDEAD in every other cycle.
   int rsp_cd = -1;
   logic [15:0] rsp_a;
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         rsp_cd     = -1;
         xa_data_rd = 16'hDEAD;
      end else begin
         if (o_xa_wr_s) resp_mem[o_xa_addr] = o_xa_data_wr;
         if (o_xa_rd_s) begin
            rsp_a      = o_xa_addr;
            rsp_cd     = (use_lat1 ? 1 : 3) - 1;
            xa_data_rd = 16'hDEAD;
         end else if (rsp_cd == 0) begin
            xa_data_rd = resp_mem.exists(rsp_a) ? resp_mem[rsp_a] : 16'h0000;
            rsp_cd     = -1;
         end else begin
            if (rsp_cd > 0) rsp_cd = rsp_cd - 1;
            xa_data_rd = 16'hDEAD;
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1; use_lat1 = 1'b0; xa_data_rd = 16'hDEAD;
      #3;
      n_checks++;
      if ({o_cmd_ready, o_busy, o_rsp_valid, o_xa_wr_s, o_xa_rd_s} !== 5'b0)
         $display("FAIL reset_ctrl: got %b expected 00000", {o_cmd_ready, o_busy, o_rsp_valid, o_xa_wr_s, o_xa_rd_s});
      else n_pass++;
      n_checks++;
      if ({o_xa_addr, o_xa_data_wr, o_rsp_rdata} !== 48'h0)
         $display("FAIL reset_data: got %h expected 0", {o_xa_addr, o_xa_data_wr, o_rsp_rdata});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_checks++;
      if (o_cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_cmd_ready);
      else n_pass++;
   endtask

   task automatic test_write(input logic [15:0] addr, input logic [15:0] data);
      int wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = addr; cmd_wdata = data;
      n_checks++;
      if (o_cmd_ready !== 1'b1) $display("FAIL wr_accept: got %b expected 1", o_cmd_ready);
      else n_pass++;
      exp_mem[addr] = data;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (o_xa_wr_s) wr_cnt++;
         if (o_xa_rd_s) rd_cnt++;
         if (o_rsp_valid) rsp_cnt++;
         if (k == 1) begin
            n_checks++;
            if ({o_xa_wr_s, o_xa_addr, o_xa_data_wr, o_cmd_ready} !== {1'b1, addr, data, 1'b0})
               $display("FAIL wr_strobe: got %b/%h/%h/rdy%b expected 1/%h/%h/rdy0",
                        o_xa_wr_s, o_xa_addr, o_xa_data_wr, o_cmd_ready, addr, data);
            else n_pass++;
         end
         if (k == 2) begin
            n_checks++;
            if (o_cmd_ready !== 1'b1) $display("FAIL wr_ready_return: got %b expected 1", o_cmd_ready);
            else n_pass++;
         end
      end
      n_checks++;
      if ({wr_cnt, rd_cnt, rsp_cnt} !== {32'd1, 32'd0, 32'd0})
         $display("FAIL wr_counts: got wr=%0d rd=%0d rsp=%0d expected 1 0 0", wr_cnt, rd_cnt, rsp_cnt);
      else n_pass++;
   endtask

   task automatic test_read(input logic [15:0] addr, input string tag);
      int lat = use_lat1 ? 1 : 3;
      int rd_cnt = 0, wr_cnt = 0, rsp_k = -1, rdy_k = -1;
      logic [15:0] e;
      exp_rsp.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = addr; rsp_ready = 1'b1;
      exp_rsp.push_back(exp_rd(addr));
      n_checks++;
      if (o_cmd_ready !== 1'b1) $display("FAIL %s_accept: got %b expected 1", tag, o_cmd_ready);
      else n_pass++;
      for (int k = 1; k <= lat + 6; k++) begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         if (o_xa_rd_s) rd_cnt++;
         if (o_xa_wr_s) wr_cnt++;
         if (k == 1) begin
            n_checks++;
            if ({o_xa_rd_s, o_xa_addr} !== {1'b1, addr})
               $display("FAIL %s_strobe: got %b/%h expected 1/%h", tag, o_xa_rd_s, o_xa_addr, addr);
            else n_pass++;
         end
         if (o_rsp_valid && rsp_k < 0) begin
            rsp_k = k;
            e = exp_rsp.pop_front();
            n_checks++;
            if (o_rsp_rdata !== e) $display("FAIL %s_rdata: got %h expected %h", tag, o_rsp_rdata, e);
            else n_pass++;
         end
         if (o_cmd_ready && rdy_k < 0) rdy_k = k;
      end
      n_checks++;
      if (rsp_k !== lat + 2) $display("FAIL %s_rsp_latency: got %0d expected %0d", tag, rsp_k, lat + 2);
      else n_pass++;
      n_checks++;
      if (rdy_k !== lat + 3) $display("FAIL %s_ready_return: got %0d expected %0d", tag, rdy_k, lat + 3);
      else n_pass++;
      n_checks++;
      if ({rd_cnt, wr_cnt} !== {32'd1, 32'd0})
         $display("FAIL %s_strobe_count: got rd=%0d wr=%0d expected 1 0", tag, rd_cnt, wr_cnt);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int k = 0, bad = 0;
      logic [15:0] e, held;
      exp_rsp.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 16'h0030; rsp_ready = 1'b0;
      exp_rsp.push_back(exp_rd(16'h0030));
      do begin
         @(posedge clk); #1;
         cmd_valid = 1'b0;
         k++;
      end while (!o_rsp_valid && k < 20);
      n_checks++;
      if (o_rsp_valid !== 1'b1) $display("FAIL bp_rsp_timeout: got %b expected 1", o_rsp_valid);
      else n_pass++;
      held = o_rsp_rdata;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!(o_rsp_valid === 1'b1 && o_rsp_rdata === held && o_cmd_ready === 1'b0 && o_busy === 1'b1)) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
      else n_pass++;
      rsp_ready = 1'b1;
      e = exp_rsp.pop_front();
      n_checks++;
      if (o_rsp_rdata !== e) $display("FAIL bp_rdata: got %h expected %h", o_rsp_rdata, e);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({o_rsp_valid, o_busy, o_cmd_ready} !== 3'b001)
         $display("FAIL bp_release: got %b expected 001", {o_rsp_valid, o_busy, o_cmd_ready});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic        ops   [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] addrs [3] = '{16'h0040, 16'h0040, 16'h0050};
      logic [15:0] datas [3] = '{16'hCAFE, 16'h0000, 16'h1111};
      int idx = 0, n_hs = 0, overlap = 0;
      bit hs = 0;
      logic [32:0] eb;
      logic [15:0] er;
      exp_rsp.delete(); exp_bus.delete();
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(posedge clk); #1;
         if (hs) idx++;
         if (o_xa_wr_s && o_xa_rd_s) overlap++;
         if (o_xa_wr_s || o_xa_rd_s) begin
            eb = (exp_bus.size() > 0) ? exp_bus.pop_front() : 33'h1FFFFFFFF;
            n_checks++;
            if ((o_xa_wr_s ? {1'b1, o_xa_addr, o_xa_data_wr} : {1'b0, o_xa_addr, 16'h0}) !== eb)
               $display("FAIL b2b_bus: got %b/%h/%h expected %h", o_xa_wr_s, o_xa_addr, o_xa_data_wr, eb);
            else n_pass++;
         end
         if (o_rsp_valid) begin
            er = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 16'hXXXX;
            n_checks++;
            if (o_rsp_rdata !== er) $display("FAIL b2b_rdata: got %h expected %h", o_rsp_rdata, er);
            else n_pass++;
         end
         if (idx < 3) begin
            cmd_valid = 1'b1; cmd_op = ops[idx]; cmd_addr = addrs[idx]; cmd_wdata = datas[idx];
         end else begin
            cmd_valid = 1'b0;
         end
         hs = cmd_valid && o_cmd_ready;
         if (hs) begin
            n_hs++;
            if (ops[idx]) begin
               exp_mem[addrs[idx]] = datas[idx];
               exp_bus.push_back({1'b1, addrs[idx], datas[idx]});
            end else begin
               exp_bus.push_back({1'b0, addrs[idx], 16'h0});
               exp_rsp.push_back(exp_rd(addrs[idx]));
            end
         end
         if (idx == 3 && !o_busy && exp_bus.size() == 0 && exp_rsp.size() == 0) break;
      end
      n_checks++;
      if (n_hs !== 3) $display("FAIL b2b_accepts: got %0d expected 3", n_hs);
      else n_pass++;
      n_checks++;
      if (overlap !== 0) $display("FAIL b2b_overlap: got %0d expected 0", overlap);
      else n_pass++;
      n_checks++;
      if (exp_bus.size() + exp_rsp.size() !== 0)
         $display("FAIL b2b_drain: got %0d outstanding expected 0", exp_bus.size() + exp_rsp.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      int stray = 0;
      exp_rsp.delete();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 16'h0060; rsp_ready = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({o_busy, o_rsp_valid} !== 2'b10) $display("FAIL rst_mid_wait: got %b expected 10", {o_busy, o_rsp_valid});
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({o_cmd_ready, o_busy, o_rsp_valid, o_xa_wr_s, o_xa_rd_s} !== 5'b0)
         $display("FAIL rst_mid_ctrl: got %b expected 00000", {o_cmd_ready, o_busy, o_rsp_valid, o_xa_wr_s, o_xa_rd_s});
      else n_pass++;
      n_checks++;
      if ({o_xa_addr, o_xa_data_wr, o_rsp_rdata} !== 48'h0)
         $display("FAIL rst_mid_data: got %h expected 0", {o_xa_addr, o_xa_data_wr, o_rsp_rdata});
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_checks++;
      if (o_cmd_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", o_cmd_ready);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (o_rsp_valid || o_busy) stray++;
      end
      n_checks++;
      if (stray !== 0) $display("FAIL rst_mid_stale: got %0d cycles expected 0", stray);
      else n_pass++;
      test_read(16'h0020, "rd_after_rst");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resp_mem[16'h0020] = 16'h1234; exp_mem[16'h0020] = 16'h1234;
      resp_mem[16'h0030] = 16'h5A5A; exp_mem[16'h0030] = 16'h5A5A;
      resp_mem[16'h0060] = 16'h7777; exp_mem[16'h0060] = 16'h7777;
      test_reset();
      test_write(16'h0010, 16'hBEEF);
      use_lat1 = 1'b1;
      test_read(16'h0020, "rd_lat1");
      use_lat1 = 1'b0;
      test_read(16'h0020, "rd_lat3");
      test_backpressure();
      test_back_to_back();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
